// File: rtl/l1_cache_pkg.sv
// Shared geometry, line types and controller states for the L1 cache.
package l1_cache_pkg;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_INDEX  = 3;
  localparam int unsigned TAG_W    = 32 - S_INDEX - S_OFFSET;
  localparam int unsigned LINE_W   = 8 << S_OFFSET;
  localparam int unsigned SETS     = 1 << S_INDEX;
  localparam int unsigned WORDS    = 1 << (S_OFFSET - 2);
  localparam int unsigned WORD_IW  = S_OFFSET - 2;

  typedef logic [LINE_W-1:0]             line_t;
  typedef logic [WORDS-1:0][31:0]        line_words_t;
  typedef logic [WORDS-1:0][3:0][7:0]    line_bytes_t;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

endpackage

// File: rtl/l1_cache_way.sv
// One way of the cache: per-set tag, valid, dirty and line storage.
// Reads are combinational on index; writes are either a byte-enabled word merge or a full line.
module l1_cache_way
  import l1_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_INDEX-1:0] index,
  input  logic [WORD_IW-1:0] word,
  input  logic               word_we,
  input  logic [3:0]         byte_en,
  input  logic [31:0]        wdata,
  input  logic               line_we,
  input  logic [TAG_W-1:0]   tag_in,
  input  line_t              line_in,
  input  logic               clr_dirty,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output line_t              line
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  line_t            data_q [SETS];

  line_bytes_t      merged;
  logic [3:0][7:0]  wbytes;

  assign valid  = valid_q[index];
  assign dirty  = dirty_q[index];
  assign tag    = tag_q[index];
  assign line   = data_q[index];
  assign wbytes = wdata;

  // Current line with the enabled byte lanes of the addressed word replaced
  always_comb begin
    merged = data_q[index];
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[word][b[1:0]] = wbytes[b[1:0]];
    end
  end

  // Status bits: reset clears, fill installs clean, writeback cleans, real write dirties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (clr_dirty) begin
      dirty_q[index] <= 1'b0;
    end else if (word_we && (byte_en != 4'b0000)) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage, intentionally not reset (valid bits gate their use)
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[index] <= line_in;
      tag_q[index]  <= tag_in;
    end else if (word_we) begin
      data_q[index] <= merged;
    end
  end

endmodule

// File: rtl/l1_cache.sv
// 2-way set-associative write-back, write-allocate cache with a blocking CPU handshake
// and 256-bit line transfers to physical memory.
module l1_cache
  import l1_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  cache_state_t       state_q, state_d;
  logic [SETS-1:0]    lru_q, lru_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [S_INDEX-1:0] miss_index_q, miss_index_d;
  logic               victim_q, victim_d;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index, index;
  logic [WORD_IW-1:0] req_word;
  logic               request, hit, hit_way, victim;
  logic [1:0]         hit_w, valid_w, dirty_w, word_we, line_we, clr_dirty;
  logic [TAG_W-1:0]   tag_w  [2];
  line_t              line_w [2];
  line_words_t        hit_words;
  logic               unused_addr;

  assign req_tag     = mem_address[31:32-TAG_W];
  assign req_index   = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_word    = mem_address[S_OFFSET-1:2];
  assign unused_addr = ^mem_address[1:0];
  assign request     = mem_read | mem_write;

  // While a miss is in flight the arrays look at the latched set, not the live address
  assign index = (state_q == CHECK) ? req_index : miss_index_q;

  for (genvar g = 0; g < 2; g++) begin : g_way
    l1_cache_way u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .index     (index),
      .word      (req_word),
      .word_we   (word_we[g]),
      .byte_en   (mem_byte_enable),
      .wdata     (mem_wdata),
      .line_we   (line_we[g]),
      .tag_in    (miss_tag_q),
      .line_in   (pmem_rdata),
      .clr_dirty (clr_dirty[g]),
      .valid     (valid_w[g]),
      .dirty     (dirty_w[g]),
      .tag       (tag_w[g]),
      .line      (line_w[g])
    );
    assign hit_w[g] = valid_w[g] && (tag_w[g] == req_tag);
  end

  assign hit       = |hit_w;
  assign hit_way   = ~hit_w[0];
  assign hit_words = hit_way ? line_w[1] : line_w[0];
  assign mem_rdata = hit_words[req_word];

  // Invalid ways are filled first (way 0 before way 1); otherwise evict the LRU way
  assign victim = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[req_index]);

  // Controller next state and outputs
  always_comb begin
    state_d      = state_q;
    lru_d        = lru_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = line_w[victim_q];
    word_we      = '0;
    line_we      = '0;
    clr_dirty    = '0;
    unique case (state_q)
      CHECK: begin
        if (request) begin
          if (hit) begin
            mem_resp           = 1'b1;
            lru_d[req_index]   = ~hit_way;
            word_we[hit_way]   = mem_write;
          end else begin
            miss_tag_d   = req_tag;
            miss_index_d = req_index;
            victim_d     = victim;
            state_d      = (valid_w[victim] && dirty_w[victim]) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_w[victim_q], miss_index_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          clr_dirty[victim_q] = 1'b1;
          state_d             = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_index_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          line_we[victim_q] = 1'b1;
          state_d           = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  // Controller state and LRU bits; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CHECK;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

  // Miss bookkeeping, only meaningful outside CHECK
  always_ff @(posedge clk) begin
    miss_tag_q   <= miss_tag_d;
    miss_index_q <= miss_index_d;
    victim_q     <= victim_d;
  end

  illegal_rw: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write))
    else $error("l1_cache: mem_read and mem_write high together");

  pmem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(pmem_read && pmem_write))
    else $error("l1_cache: pmem_read and pmem_write high together");

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: physical memory responder, set-level cache model and flat CPU memory view.
module tb_l1_cache;
  import l1_cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [3:0]   mem_byte_enable = '0;
  logic [31:0]  mem_wdata = '0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic expired(input string name);
    n_checks++;
    $display("FAIL %s: no mem_resp within cycle budget", name);
  endtask

  // ---------------- physical memory ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic line_t init_line(input logic [31:0] la);
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  line_t        pm [logic [31:0]];
  int           resp_delay = 5;
  int           resp_cnt = 0;
  logic         log_wr   [$];
  logic [31:0]  log_addr [$];
  line_t        log_data [$];

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (rst_n && (pmem_read || pmem_write)) begin
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin
        resp_cnt  = 0;
        pmem_resp = 1'b1;
        log_wr.push_back(pmem_write);
        log_addr.push_back(pmem_address);
        log_data.push_back(pmem_wdata);
        if (pmem_write) pm[pmem_address] = pmem_wdata;
        else pmem_rdata = pm.exists(pmem_address) ? pm[pmem_address] : init_line(pmem_address);
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // ---------------- model ----------------
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  logic [23:0] m_tag   [8][2];
  int          m_mru   [8];
  logic [31:0] wmap [logic [31:0]];  // CPU writes not yet guaranteed in memory
  logic [31:0] cmap [logic [31:0]];  // words committed to memory by writebacks

  function automatic logic [31:0] cpu_view(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    if (wmap.exists(wa)) return wmap[wa];
    if (cmap.exists(wa)) return cmap[wa];
    return init_word(wa);
  endfunction

  function automatic line_t view_line(input logic [31:0] la);
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = cpu_view(la + 32'(i * 4));
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_mru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    wmap.delete();
  endtask

  // ---------------- per-cycle compare ----------------
  logic [31:0] exp_rdata = '0;
  bit          rd_armed = 1'b0;
  bit          wb_seen = 1'b0;
  logic [31:0] wb_addr_hold;
  line_t       wb_data_hold;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!(mem_read || mem_write)) chk("idle_no_resp", mem_resp, 1'b0);
      if (mem_resp && rd_armed) chk("rdata", mem_rdata, exp_rdata);
      if (pmem_read || pmem_write) begin
        chk("pmem_exclusive", pmem_read && pmem_write, 1'b0);
        chk("pmem_aligned", pmem_address[4:0], 5'd0);
      end
      if (pmem_write) begin
        if (wb_seen) begin
          chk("wb_addr_stable", pmem_address, wb_addr_hold);
          chk("wb_data_stable", pmem_wdata, wb_data_hold);
        end
        wb_seen      = 1'b1;
        wb_addr_hold = pmem_address;
        wb_data_hold = pmem_wdata;
      end else begin
        wb_seen = 1'b0;
      end
    end
  end

  // ---------------- one CPU access ----------------
  task automatic access(input string name, input bit wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input int dly,
                        output logic [31:0] got, output int lat);
    int          set = int'(a[7:5]);
    logic [23:0] tg = a[31:8];
    logic [31:0] la = {a[31:5], 5'b0};
    logic [31:0] wb_la = '0;
    logic [31:0] old, nw;
    int          way = -1;
    int          vic = 0;
    bit          wb = 1'b0;
    bit          done = 1'b0;
    int          exp_lat, n_exp;

    for (int w = 0; w < 2; w++) if (m_valid[set][w] && m_tag[set][w] == tg) way = w;
    if (way < 0) begin
      vic   = !m_valid[set][0] ? 0 : (!m_valid[set][1] ? 1 : 1 - m_mru[set]);
      wb    = m_valid[set][vic] && m_dirty[set][vic];
      wb_la = {m_tag[set][vic], a[7:5], 5'b0};
    end
    exp_lat = (way >= 0) ? 1 : 2 + dly + (wb ? dly : 0);
    n_exp   = (way >= 0) ? 0 : (wb ? 2 : 1);

    log_wr.delete();
    log_addr.delete();
    log_data.delete();
    resp_delay = dly;
    exp_rdata  = cpu_view(a);

    @(posedge clk); #1;
    mem_address     = a;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    rd_armed        = !wr;
    lat = 0;
    got = 'x;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_resp) begin
        done = 1'b1;
        got  = mem_rdata;
      end
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rd_armed  = 1'b0;

    if (!done) expired(name);
    else chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_xfers"}, log_wr.size(), n_exp);
    if (log_wr.size() == n_exp && n_exp > 0) begin
      if (wb) begin
        chk({name, "_wb_is_write"}, log_wr[0], 1'b1);
        chk({name, "_wb_addr"}, log_addr[0], wb_la);
        chk({name, "_wb_data"}, log_data[0], view_line(wb_la));
      end
      chk({name, "_fill_is_read"}, log_wr[n_exp-1], 1'b0);
      chk({name, "_fill_addr"}, log_addr[n_exp-1], la);
    end

    // model update
    if (way < 0) begin
      if (wb) for (int i = 0; i < 8; i++) cmap[wb_la + 32'(i*4)] = cpu_view(wb_la + 32'(i*4));
      way = vic;
      m_valid[set][way] = 1'b1;
      m_dirty[set][way] = 1'b0;
      m_tag[set][way]   = tg;
    end
    m_mru[set] = way;
    if (wr && be != 4'b0000) begin
      m_dirty[set][way] = 1'b1;
      old = cpu_view(a);
      for (int b = 0; b < 4; b++) nw[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
      wmap[{a[31:2], 2'b00}] = nw;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] got;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_resp", mem_resp, 1'b0);
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_write", pmem_write, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // cold miss, then hit
    access("cold_read", 1'b0, 32'h0000_0104, 4'h0, 32'h0, 5, got, lat);
    chk("cold_rdata_lit", got, 32'hDEAD_BEEF);
    chk("cold_latency_lit", lat, 7);
    chk("cold_fill_addr_lit", (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF, 32'h100);
    access("hit_read", 1'b0, 32'h0000_0104, 4'h0, 32'h0, 5, got, lat);
    chk("hit_latency_lit", lat, 1);

    // partial write hit
    access("write_hit", 1'b1, 32'h0000_0104, 4'b0011, 32'h1234_5678, 5, got, lat);
    access("read_merged", 1'b0, 32'h0000_0104, 4'h0, 32'h0, 5, got, lat);
    chk("merged_rdata_lit", got, 32'hDEAD_5678);

    // second way of set 0, dirty it, then touch way 0
    access("fill_way1", 1'b0, 32'h0000_1100, 4'h0, 32'h0, 5, got, lat);
    access("dirty_way1", 1'b1, 32'h0000_1104, 4'hF, 32'hCAFE_F00D, 5, got, lat);
    access("touch_way0", 1'b0, 32'h0000_0100, 4'h0, 32'h0, 5, got, lat);

    // evict dirty 0x1100 with a slow memory
    access("evict_dirty", 1'b0, 32'h0000_2100, 4'h0, 32'h0, 10, got, lat);
    chk("evict_wb_addr_lit", (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF, 32'h1100);
    chk("evict_wb_word1_lit", (log_data.size() > 0) ? log_data[0][63:32] : 32'h0,
        32'hCAFE_F00D);
    chk("evict_latency_lit", lat, 22);

    // zero byte-enable write leaves the line clean
    access("write_be0", 1'b1, 32'h0000_2104, 4'b0000, 32'hFFFF_FFFF, 3, got, lat);
    access("evict_0x100", 1'b0, 32'h0000_3100, 4'h0, 32'h0, 3, got, lat);
    access("evict_clean", 1'b0, 32'h0000_4104, 4'h0, 32'h0, 3, got, lat);
    chk("clean_evict_xfers_lit", log_wr.size(), 1);

    // write-allocate in another set
    access("write_miss", 1'b1, 32'h0000_0048, 4'hF, 32'hA5A5_0001, 4, got, lat);
    access("read_alloc", 1'b0, 32'h0000_0048, 4'h0, 32'h0, 4, got, lat);
    chk("alloc_rdata_lit", got, 32'hA5A5_0001);
    access("read_alloc_w3", 1'b0, 32'h0000_004C, 4'h0, 32'h0, 4, got, lat);

    // reset during a fill
    resp_delay = 5;
    @(posedge clk); #1;
    mem_address = 32'h0000_5020;
    mem_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_fill_active", pmem_read, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("abort_pmem_read", pmem_read, 1'b0);
    chk("abort_pmem_write", pmem_write, 1'b0);
    chk("abort_mem_resp", mem_resp, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    access("post_reset_4100", 1'b0, 32'h0000_4104, 4'h0, 32'h0, 5, got, lat);
    chk("post_reset_miss_lit", lat, 7);
    access("post_reset_0048", 1'b0, 32'h0000_0048, 4'h0, 32'h0, 5, got, lat);
    chk("lost_dirty_rdata_lit", got, 32'hFFB7_0048);
    access("post_reset_0104", 1'b0, 32'h0000_0104, 4'h0, 32'h0, 5, got, lat);
    chk("committed_rdata_lit", got, 32'hDEAD_5678);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
